coco_spi_host: RTL and testbench

//  SPI master command engine: the initiator end of the FPGA disk/SRAM command link (the AVR side, in RTL).

---
 rtl/coco_spi_host.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_coco_spi_host.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coco_spi_host.sv
// coco_spi_host: SPI master command engine for the FPGA disk/SRAM command link.
// Accepts one host command at a time and sends it as the byte sequence the FPGA SPI
// command decoder expects. For READ and READ_STATUS it returns the second MISO byte.
//
// Ports:
//   clock_50  - system clock, all logic on posedge
//   reset     - asynchronous active-high reset
//   cmd_valid / cmd_ready - command handshake (accept when both high)
//   cmd_op    - 0=ADDR 1=WRITE 2=READ 3=READ_STATUS 4=DEVCON, 5-7 dropped
//   cmd_addr  - 16-bit address for ADDR
//   cmd_data  - payload for WRITE/DEVCON
//   rsp_valid - one-cycle pulse, rsp_data holds the READ/READ_STATUS result
//   rsp_data  - last response byte, held until the next response
//   busy      - high from the cycle after accept until back in idle
//   sclk/mosi/miso/ss - SPI mode 0 pins, ss active low
module coco_spi_host #(
  parameter int unsigned CLK_DIV    = 6,  // clocks per SCLK half period, >= 2
  parameter int unsigned GAP_CYCLES = 32, // idle clocks between bytes, >= 1
  parameter int unsigned SS_HIGH    = 8   // minimum ss-high clocks after a command, >= 1
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ss
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] SsLast  = CntW'(SS_HIGH - 1);

  localparam logic [2:0] OpAddr   = 3'd0;
  localparam logic [2:0] OpWrite  = 3'd1;
  localparam logic [2:0] OpRead   = 3'd2;
  localparam logic [2:0] OpStatus = 3'd3;
  localparam logic [2:0] OpDevcon = 3'd4;

  typedef enum logic [2:0] {
    StIdle, StDrop, StSetup, StShift, StGap, StHold, StDesel
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [1:0]      last_q, last_d;
  logic [2:0]      op_q, op_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic            miso_s1_q, miso_s1_d;
  logic            miso_s2_q, miso_s2_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            ss_q, ss_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;

  logic [7:0] first_byte;
  logic [7:0] next_byte;
  logic [7:0] rx_shift;
  logic       is_read;

  // Byte idx of the frame for a given (latched) command.
  function automatic logic [7:0] tx_byte(input logic [2:0]  op,
                                         input logic [1:0]  idx,
                                         input logic [15:0] addr,
                                         input logic [7:0]  data);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      2'd0: b = {5'd0, op + 3'd1};
      2'd1: begin
        if (op == OpAddr) begin
          b = addr[15:8];
        end else if (op == OpWrite || op == OpDevcon) begin
          b = data;
        end
      end
      2'd2:    b = addr[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign first_byte = tx_byte(cmd_op, 2'd0, cmd_addr, cmd_data);
  assign next_byte  = tx_byte(op_q, byte_q + 2'd1, addr_q, data_q);
  // The synchroniser delays miso by two clocks, so at the end of the high phase its
  // output still holds the bit the slave presented for this rising edge.
  assign rx_shift   = {rx_q[6:0], miso_s2_q};
  assign is_read    = (op_q == OpRead) || (op_q == OpStatus);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    last_d      = last_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    miso_s1_d   = miso;
    miso_s2_d   = miso_s1_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ss_d        = ss_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d        = cmd_op;
          addr_d      = cmd_addr;
          data_d      = cmd_data;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (cmd_op > OpDevcon) begin
            state_d = StDrop;
          end else begin
            state_d = StSetup;
            ss_d    = 1'b0;
            tx_d    = first_byte;
            mosi_d  = first_byte[7];
            last_d  = (cmd_op == OpAddr) ? 2'd2 : 2'd1;
            byte_d  = 2'd0;
            bit_d   = 3'd0;
            cnt_d   = '0;
          end
        end
      end

      StDrop: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end

      StSetup: begin
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StShift: begin
        if (cnt_q != DivLast) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            rx_d   = rx_shift;
            bit_d  = bit_q + 3'd1;
            if (bit_q != 3'd7) begin
              tx_d   = {tx_q[6:0], 1'b0};
              mosi_d = tx_q[6];
            end else if (byte_q != last_q) begin
              byte_d  = byte_q + 2'd1;
              tx_d    = next_byte;
              mosi_d  = next_byte[7];
              state_d = StGap;
            end else begin
              mosi_d  = 1'b0;
              state_d = StHold;
            end
          end
        end
      end

      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StHold: begin
        // First hold cycle: rx_q already holds the final byte.
        if (cnt_q == '0 && is_read) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_q;
        end
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          ss_d    = 1'b1;
          state_d = StDesel;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDesel: begin
        if (cnt_q == SsLast) begin
          cnt_d       = '0;
          state_d     = StIdle;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      byte_q      <= 2'd0;
      last_q      <= 2'd0;
      op_q        <= 3'd0;
      addr_q      <= 16'h0000;
      data_q      <= 8'h00;
      tx_q        <= 8'h00;
      rx_q        <= 8'h00;
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ss_q        <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      miso_s1_q   <= miso_s1_d;
      miso_s2_q   <= miso_s2_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ss_q        <= ss_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign ss        = ss_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_coco_spi_host.sv
// tb_coco_spi_host: directed bench for coco_spi_host with a mode-0 SPI slave model.
`timescale 1ns/1ps
module tb_coco_spi_host;

  localparam int unsigned ClkDiv    = 2;
  localparam int unsigned GapCycles = 32;
  localparam int unsigned SsHigh    = 8;
  // Between bytes sclk stays low for the gap plus the low half of the next first bit.
  localparam int          GapExp    = GapCycles + ClkDiv;

  logic        clock_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op   = 3'd0;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_data = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        ss;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] slave_resp = 8'h00;

  // Monitor state (written only by the monitor processes).
  int         win_rises   = 0;
  int         stray_rises = 0;
  int         ss_falls    = 0;
  int         rsp_pulses  = 0;
  int         ss_hi       = 0;
  logic [7:0] win_sh      = 8'h00;
  logic [7:0] win_bytes[$];
  int         gaps[$];
  time        t_fall      = 0;
  time        t_ss_rise   = 0;
  int         s_cnt       = 0;

  coco_spi_host #(
    .CLK_DIV   (ClkDiv),
    .GAP_CYCLES(GapCycles),
    .SS_HIGH   (SsHigh)
  ) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .ss       (ss)
  );

  always #5 clock_50 = ~clock_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave stream: byte 0 = C3, byte 1 = slave_resp, then zeros; bit n is shown after fall n.
  function automatic logic slave_bit(input int n, input logic [7:0] resp);
    logic [23:0] s;
    s = {8'hC3, resp, 8'h00};
    if (n < 24) return s[5'(23 - n)];
    return 1'b0;
  endfunction

  initial begin
    miso = 1'b0;
    forever begin
      @(negedge ss);
      s_cnt = 0;
      miso  = slave_bit(0, slave_resp);
      while (!ss) begin
        @(negedge sclk or posedge ss);
        if (!ss) begin
          s_cnt++;
          miso = slave_bit(s_cnt, slave_resp);
        end
      end
    end
  end

  // Window monitor: ss fall starts a new window, sclk rises capture mosi.
  initial begin
    forever begin
      @(posedge sclk or negedge ss);
      if (sclk) begin
        if (ss) begin
          stray_rises++;
        end else begin
          if (win_rises > 0 && win_rises % 8 == 0) gaps.push_back(int'(($time - t_fall) / 10));
          win_sh = {win_sh[6:0], mosi};
          win_rises++;
          if (win_rises % 8 == 0) win_bytes.push_back(win_sh);
        end
      end else begin
        ss_falls++;
        ss_hi     = int'(($time - t_ss_rise) / 10);
        win_rises = 0;
        win_sh    = 8'h00;
        win_bytes.delete();
        gaps.delete();
      end
    end
  end

  initial begin
    forever begin
      @(negedge sclk or posedge ss);
      if (ss) t_ss_rise = $time;
      else    t_fall    = $time;
    end
  end

  initial begin
    forever begin
      @(negedge clock_50);
      if (rsp_valid) rsp_pulses++;
    end
  end

  // Returns 1 ns after the accepting edge, with operands scrambled.
  task automatic send_cmd(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] data);
    int n;
    n = 0;
    @(negedge clock_50);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    while (!cmd_ready && n < 1000) begin
      @(negedge clock_50);
      n++;
    end
    if (!cmd_ready) check("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clock_50);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_addr  = ~addr;
    cmd_data  = ~data;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock_50);
      n++;
    end while (!(cmd_ready && !busy) && n < 5000);
    check({tag, "_idle"}, {31'd0, cmd_ready & ~busy}, 32'd1);
  endtask

  task automatic wait_rises(input string tag, input int target);
    int n;
    n = 0;
    while (win_rises < target && n < 2000) begin
      @(negedge clock_50);
      n++;
    end
    if (win_rises < target) check({tag, "_rise_timeout"}, win_rises, target);
  endtask

  task automatic check_window(input string tag, input int nbytes, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp_b[3];
    exp_b[0] = b0;
    exp_b[1] = b1;
    exp_b[2] = b2;
    check({tag, "_rises"}, win_rises, 8 * nbytes);
    check({tag, "_nbytes"}, win_bytes.size(), nbytes);
    for (int i = 0; i < nbytes; i++) begin
      check($sformatf("%s_byte%0d", tag, i),
            (i < win_bytes.size()) ? {24'd0, win_bytes[i]} : 32'hDEAD_BEEF, {24'd0, exp_b[i]});
    end
    check({tag, "_ngaps"}, gaps.size(), nbytes - 1);
    for (int i = 0; i < gaps.size(); i++) begin
      check($sformatf("%s_gap%0d", tag, i), gaps[i], GapExp);
    end
  endtask

  task automatic check_started(input string tag);
    check({tag, "_ss_low"}, {31'd0, ss}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_ready_low"}, {31'd0, cmd_ready}, 32'd0);
    check({tag, "_mosi_bit7"}, {31'd0, mosi}, 32'd0);
  endtask

  initial begin
    int p0;
    int f0;
    int s0;
    int r0;

    reset = 1'b1;
    repeat (3) @(negedge clock_50);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_ss", {31'd0, ss}, 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clock_50);

    // 1: ADDR FF48
    p0 = rsp_pulses;
    f0 = ss_falls;
    send_cmd(3'd0, 16'hFF48, 8'h00);
    check_started("t1");
    wait_idle("t1");
    check_window("t1", 3, 8'h01, 8'hFF, 8'h48);
    check("t1_one_window", ss_falls - f0, 1);
    check("t1_no_rsp", rsp_pulses - p0, 0);
    check("t1_stray", stray_rises, 0);

    // 2: WRITE A5 then DEVCON 03 back to back
    send_cmd(3'd1, 16'h0000, 8'hA5);
    check_started("t2w");
    wait_idle("t2w");
    check_window("t2w", 2, 8'h02, 8'hA5, 8'h00);
    send_cmd(3'd4, 16'h0000, 8'h03);
    wait_idle("t2d");
    check_window("t2d", 2, 8'h05, 8'h03, 8'h00);
    check("t2_ss_high_min", {31'd0, ss_hi >= int'(SsHigh)}, 32'd1);

    // 3: READ, slave returns 3C
    slave_resp = 8'h3C;
    p0 = rsp_pulses;
    send_cmd(3'd2, 16'h1234, 8'h77);
    wait_idle("t3");
    check_window("t3", 2, 8'h03, 8'h00, 8'h00);
    check("t3_rsp_pulses", rsp_pulses - p0, 1);
    check("t3_rsp_data", {24'd0, rsp_data}, 32'h3C);

    // 4: READ_STATUS returns 04, then a WRITE must leave rsp_data alone
    slave_resp = 8'h04;
    p0 = rsp_pulses;
    send_cmd(3'd3, 16'h0000, 8'h00);
    wait_idle("t4s");
    check_window("t4s", 2, 8'h04, 8'h00, 8'h00);
    check("t4_status_pulses", rsp_pulses - p0, 1);
    check("t4_status_data", {24'd0, rsp_data}, 32'h04);
    slave_resp = 8'hEE;
    p0 = rsp_pulses;
    send_cmd(3'd1, 16'h0000, 8'h11);
    wait_rises("t4w", 12);
    check("t4_data_mid_write", {24'd0, rsp_data}, 32'h04);
    wait_idle("t4w");
    check_window("t4w", 2, 8'h02, 8'h11, 8'h00);
    check("t4_data_after_write", {24'd0, rsp_data}, 32'h04);
    check("t4_write_no_rsp", rsp_pulses - p0, 0);

    // 5: invalid op 6 is dropped
    p0 = rsp_pulses;
    f0 = ss_falls;
    s0 = stray_rises;
    r0 = win_rises;
    send_cmd(3'd6, 16'hFFFF, 8'hFF);
    check("t5_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("t5_ss_high", {31'd0, ss}, 32'd1);
    @(posedge clock_50);
    #1;
    check("t5_ready_back", {31'd0, cmd_ready}, 32'd1);
    repeat (20) @(negedge clock_50);
    check("t5_no_ss", ss_falls - f0, 0);
    check("t5_no_sclk", (stray_rises - s0) + (win_rises - r0), 0);
    check("t5_no_rsp", rsp_pulses - p0, 0);

    // 6: reset in the middle of the ADDR hi byte, then a clean ADDR 0000
    send_cmd(3'd0, 16'hABCD, 8'h00);
    wait_rises("t6", 12);
    check("t6_sclk_high_before", {31'd0, sclk}, 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rst_ss", {31'd0, ss}, 32'd1);
    check("t6_rst_sclk", {31'd0, sclk}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (3) @(negedge clock_50);
    reset = 1'b0;
    repeat (2) @(negedge clock_50);
    f0 = ss_falls;
    send_cmd(3'd0, 16'h0000, 8'h00);
    wait_idle("t6n");
    check_window("t6n", 3, 8'h01, 8'h00, 8'h00);
    check("t6_one_window", ss_falls - f0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected summary before 2 ms");
    $fatal(1);
  end

endmodule
